// File: rtl/onchip_ram_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// Define ONCHIP_RAM_ARB_ADDR_CHECK_EN to block and flag addresses >= DEPTH.
module onchip_ram_port_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 393216
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic [31:0]       ram_writedata,
    output logic              ram_chipselect,
    output logic              ram_write,
    input  logic [31:0]       ram_readdata,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    state_t state;
    state_t state_nx;

    logic              pri;
    logic              sel;
    logic              rd_q;
    logic              oor_q;
    logic              err_q;
    logic              req0;
    logic              req1;
    logic              gnt0;
    logic              gnt1;
    logic              gnt;
    logic              g_wr;
    logic              g_oor;
    logic [ADDR_W-1:0] g_addr;
    logic [3:0]        g_be;
    logic [31:0]       g_wd;
    logic [31:0]       cap_data;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;
    assign gnt  = gnt0 | gnt1;

    assign g_wr   = gnt1 ? m1_write      : m0_write;
    assign g_addr = gnt1 ? m1_address    : m0_address;
    assign g_be   = gnt1 ? m1_byteenable : m0_byteenable;
    assign g_wd   = gnt1 ? m1_writedata  : m0_writedata;

`ifdef ONCHIP_RAM_ARB_ADDR_CHECK_EN
    assign g_oor = 64'(g_addr) >= 64'(DEPTH);
`else
    logic unused_depth;
    assign unused_depth = ^DEPTH;
    assign g_oor = 1'b0;
`endif

    // Blocked reads still complete, returning zero.
    assign cap_data = oor_q ? 32'd0 : ram_readdata;
    assign err      = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (gnt) state_nx = ISSUE;
            ISSUE:   state_nx = rd_q ? CAPTURE : IDLE;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // pri=1 means m1 wins a tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE && !reset) begin
            gnt0 = req0 && (!req1 || !pri);
            gnt1 = req1 && (!req0 || pri);
        end
        m0_waitrequest = ~gnt0;
        m1_waitrequest = ~gnt1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pri              <= 1'b0;
            sel              <= 1'b0;
            rd_q             <= 1'b0;
            oor_q            <= 1'b0;
            err_q            <= 1'b0;
            ram_address      <= '0;
            ram_byteenable   <= '0;
            ram_writedata    <= '0;
            ram_chipselect   <= 1'b0;
            ram_write        <= 1'b0;
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
        end else begin
            ram_chipselect   <= 1'b0;
            ram_write        <= 1'b0;
            err_q            <= 1'b0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            if (gnt) begin
                pri            <= ~gnt1;
                sel            <= gnt1;
                rd_q           <= ~g_wr;
                oor_q          <= g_oor;
                err_q          <= g_oor;
                ram_address    <= g_addr;
                ram_byteenable <= g_be;
                ram_writedata  <= g_wd;
                ram_chipselect <= ~g_oor;
                ram_write      <= g_wr & ~g_oor;
            end
            if (state == CAPTURE) begin
                if (sel) begin
                    m1_readdata      <= cap_data;
                    m1_readdatavalid <= 1'b1;
                end else begin
                    m0_readdata      <= cap_data;
                    m0_readdatavalid <= 1'b1;
                end
            end
        end
    end

endmodule
